instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue_pkg.sv | 7 +
 rtl/queue_storage.sv | 26 ++
 rtl/instruction_queue.sv | 66 ++++++
 tb/tb_instruction_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: shared queue depth default and pointer-width helper
package instruction_queue_pkg;
  localparam int DEFAULT_DEPTH = 4;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/queue_storage.sv
// queue_storage: DEPTH-entry register array, one write port, one async read port
module queue_storage
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = 40,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: in-order fetch-to-decode buffer with flush and registered occupancy
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           PC,
  input  logic [IWIDTH-1:0]          Instruction,
  input  logic                       inValid,
  output logic                       fetchEnable,
  input  logic                       flush,
  input  logic                       decodeReady,
  output logic                       outValid,
  output logic [WIDTH-1:0]           outPC,
  output logic [IWIDTH-1:0]          outInstruction,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [IWIDTH-1:0] instruction;
  } entry_t;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  entry_t        wr_entry, rd_entry;
  assign fetchEnable = count_q != CW'(DEPTH);
  assign outValid    = count_q != '0;
  assign count       = count_q;
  assign push        = inValid && fetchEnable && !flush;
  assign pop         = outValid && decodeReady && !flush;
  assign wr_entry    = '{pc: PC, instruction: Instruction};
  // Explicit wrap keeps non-power-of-two depths correct
  always_comb begin
    wr_d    = flush ? '0 : !push ? wr_q : (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    rd_d    = flush ? '0 : !pop ? rd_q : (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    count_d = flush ? '0 : (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  queue_storage #(.DEPTH(DEPTH), .W($bits(entry_t)), .PW(PW)) u_storage (
    .clock   (clock),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_q),
    .rdata_o (rd_entry)
  );
  assign outPC          = rd_entry.pc;
  assign outInstruction = rd_entry.instruction;
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: vector table plus scoreboard checks of the instruction queue
module tb_instruction_queue;
  localparam int D = 4;
  logic        clock = 1'b0, reset = 1'b1;
  logic [7:0]  pc = '0;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0, flush = 1'b0, decode_ready = 1'b0;
  logic        fetch_enable, out_valid;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;
  int errors = 0, checks = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ins;
  } ent_t;
  ent_t sb[$];

  typedef struct {
    logic       iv;
    logic [7:0] pc;
    logic       dr;
    logic       fl;
    int         cnt;
    logic       fe;
    logic [7:0] head;
  } vec_t;
  vec_t vecs[$];

  instruction_queue #(.WIDTH(8), .IWIDTH(32), .DEPTH(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (pc),
    .Instruction    (instr),
    .inValid        (in_valid),
    .fetchEnable    (fetch_enable),
    .flush          (flush),
    .decodeReady    (decode_ready),
    .outValid       (out_valid),
    .outPC          (out_pc),
    .outInstruction (out_instr),
    .count          (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ins_of(input logic [7:0] p);
    return {8'hC3, p, ~p, 8'h5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; before the edge compare DUT against the scoreboard, then update it.
  task automatic step(input logic iv, input logic [7:0] p, input logic dr, input logic fl);
    bit do_push, do_pop;
    in_valid = iv; pc = p; instr = ins_of(p); decode_ready = dr; flush = fl;
    @(negedge clock);
    chk("sb_count", 32'(count), 32'(sb.size()));
    chk("sb_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("sb_fe", 32'(fetch_enable), 32'(sb.size() != D));
    if (sb.size() != 0) begin
      chk("sb_pc", 32'(out_pc), 32'(sb[0].pc));
      chk("sb_ins", out_instr, sb[0].ins);
    end
    if (fl) sb.delete();
    else begin
      do_push = iv && sb.size() != D;
      do_pop  = dr && sb.size() != 0;
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{pc: p, ins: ins_of(p)});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state while reset is held
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_fe", 32'(fetch_enable), 1);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_ins", out_instr, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Three pushes, flush, fill to full with blocked 0x24, pop-while-full, drain
    vecs = '{
      '{1, 8'h10, 0, 0, 1, 1, 8'h10}, '{1, 8'h11, 0, 0, 2, 1, 8'h10},
      '{1, 8'h12, 0, 0, 3, 1, 8'h10}, '{0, 8'h00, 0, 1, 0, 1, 8'h00},
      '{1, 8'h20, 0, 0, 1, 1, 8'h20}, '{1, 8'h21, 0, 0, 2, 1, 8'h20},
      '{1, 8'h22, 0, 0, 3, 1, 8'h20}, '{1, 8'h23, 0, 0, 4, 0, 8'h20},
      '{1, 8'h24, 0, 0, 4, 0, 8'h20}, '{1, 8'h24, 0, 0, 4, 0, 8'h20},
      '{1, 8'h24, 1, 0, 3, 1, 8'h21}, '{0, 8'h00, 1, 0, 2, 1, 8'h22},
      '{0, 8'h00, 1, 0, 1, 1, 8'h23}, '{0, 8'h00, 1, 0, 0, 1, 8'h00}
    };
    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].pc, vecs[i].dr, vecs[i].fl);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_fe", i), 32'(fetch_enable), 32'(vecs[i].fe));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].cnt != 0));
      if (vecs[i].cnt != 0) chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vecs[i].head));
    end

    // Steady stream with two entries queued; pointers wrap several times
    step(1, 8'h50, 0, 0);
    step(1, 8'h51, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h52 + i), 1, 0);
      chk("stream_count", 32'(count), 2);
      chk("stream_pc", 32'(out_pc), 32'(8'h51 + i));
    end

    // Flush beats simultaneous push and pop
    step(0, 8'h00, 1, 1);
    step(1, 8'h30, 0, 0);
    step(1, 8'h31, 0, 0);
    step(1, 8'h32, 0, 0);
    step(1, 8'h33, 1, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    step(1, 8'h40, 0, 0);
    chk("post_flush_pc", 32'(out_pc), 32'h40);
    chk("post_flush_ins", out_instr, ins_of(8'h40));

    // decodeReady on empty does nothing
    step(0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    chk("empty_pop_count", 32'(count), 0);
    chk("empty_pop_valid", 32'(out_valid), 0);

    // Asynchronous reset mid-cycle with two entries queued
    step(1, 8'h70, 0, 0);
    step(1, 8'h71, 0, 0);
    chk("pre_rst_count", 32'(count), 2);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_pc", 32'(out_pc), 0);
    chk("arst_ins", out_instr, 0);
    chk("arst_fe", 32'(fetch_enable), 1);
    sb.delete();
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    step(1, 8'h60, 0, 0);
    chk("rst_push_pc", 32'(out_pc), 32'h60);
    chk("rst_push_count", 32'(count), 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
